// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-cycle timing and control-flow sequencer for the 4-bit core.
// Generates the 8-phase cycle (A1,A2,A3,M1,M2,X1,X2,X3), latches the OPR/OPA nibbles,
// tracks two-word instructions and issues one-clock push/pop/target-load commands to the
// PC stack for JUN, JMS, JCN, ISZ and BBL.
//
// Optional feature macro: STACK_CHECK_EN (stack depth counter plus sticky over/underflow).
//
// Ports:
//   i_clock, i_reset     clock, synchronous active-high reset
//   i_data_in[3:0]       data bus; OPR sampled in cycle 3, OPA in cycle 4
//   i_page_in[3:0]       PC[11:8] of the current fetch; high nibble of JCN/ISZ targets
//   i_test_n             TEST pin, active-low (JCN)
//   i_carry_in           ALU carry flag (JCN)
//   i_acc_zero           accumulator is zero (JCN)
//   i_isz_nonzero        ISZ incremented register is non-zero
//   o_cycle[2:0]         current phase 0..7
//   o_sync               high while o_cycle == 7
//   o_opr, o_opa [3:0]   latched opcode / operand nibbles
//   o_second_word        current fetch is word 2 of a two-word instruction
//   o_control[1:0]       PC stack command: 0 hold, 1 push, 2 pop
//   o_target[11:0]       jump target for the PC stack
//   o_target_load        write o_target into the current stack slot
//   o_depth              stack depth (0 when STACK_CHECK_EN is undefined)
//   o_stack_err          sticky overflow/underflow (0 when STACK_CHECK_EN is undefined)
module fetch_sequencer #(
  parameter int unsigned STACK_SLOTS = 4
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [3:0]                     i_data_in,
  input  logic [3:0]                     i_page_in,
  input  logic                           i_test_n,
  input  logic                           i_carry_in,
  input  logic                           i_acc_zero,
  input  logic                           i_isz_nonzero,
  output logic [2:0]                     o_cycle,
  output logic                           o_sync,
  output logic [3:0]                     o_opr,
  output logic [3:0]                     o_opa,
  output logic                           o_second_word,
  output logic [1:0]                     o_control,
  output logic [11:0]                    o_target,
  output logic                           o_target_load,
  output logic [$clog2(STACK_SLOTS)-1:0] o_depth,
  output logic                           o_stack_err
);

  localparam logic [1:0] CtlHold = 2'd0;
  localparam logic [1:0] CtlPush = 2'd1;
  localparam logic [1:0] CtlPop  = 2'd2;

  // Class of the word-1 opcode; anything other than ClsNone occupies two words.
  typedef enum logic [2:0] {ClsNone, ClsJcn, ClsFim, ClsJun, ClsJms, ClsIsz} cls_e;

  logic [2:0]  r_cycle, w_cycle_d;
  logic [3:0]  r_opr, w_opr_d;
  logic [3:0]  r_opa, w_opa_d;
  logic [3:0]  r_hi, w_hi_d;
  cls_e        r_cls, w_cls_d, w_cls_dec;
  logic        r_jump, w_jump_d;
  logic        r_second_word, w_second_word_d;
  logic [1:0]  r_control, w_control_d;
  logic [11:0] r_target, w_target_d;
  logic        r_target_load, w_target_load_d;
  logic        w_jcn_jump;

  always_comb begin
    w_cls_dec = ClsNone;
    case (r_opr)
      4'h1:    w_cls_dec = ClsJcn;
      4'h2:    w_cls_dec = r_opa[0] ? ClsNone : ClsFim;
      4'h4:    w_cls_dec = ClsJun;
      4'h5:    w_cls_dec = ClsJms;
      4'h7:    w_cls_dec = ClsIsz;
      default: w_cls_dec = ClsNone;
    endcase
  end

  // r_hi holds the JCN condition code during word 2.
  assign w_jcn_jump = ((i_acc_zero & r_hi[2]) | (i_carry_in & r_hi[1]) | (~i_test_n & r_hi[0]))
                      ^ r_hi[3];

  // Outputs are registered one phase early so each command is high during its own phase.
  always_comb begin
    w_cycle_d       = r_cycle + 3'd1;
    w_opr_d         = r_opr;
    w_opa_d         = r_opa;
    w_hi_d          = r_hi;
    w_cls_d         = r_cls;
    w_jump_d        = r_jump;
    w_second_word_d = r_second_word;
    w_control_d     = CtlHold;
    w_target_d      = r_target;
    w_target_load_d = 1'b0;
    case (r_cycle)
      3'd3: w_opr_d = i_data_in;
      3'd4: w_opa_d = i_data_in;
      3'd5: begin
        if (!r_second_word) begin
          w_cls_d  = w_cls_dec;
          w_hi_d   = r_opa;
          w_jump_d = 1'b0;
        end else begin
          case (r_cls)
            ClsJcn:  w_jump_d = w_jcn_jump;
            ClsIsz:  w_jump_d = i_isz_nonzero;
            ClsJms:  w_control_d = CtlPush;
            default: ;
          endcase
        end
      end
      3'd6: begin
        if (r_second_word) begin
          if (r_cls == ClsJun || r_cls == ClsJms) begin
            w_target_d      = {r_hi, r_opr, r_opa};
            w_target_load_d = 1'b1;
          end else if ((r_cls == ClsJcn || r_cls == ClsIsz) && r_jump) begin
            w_target_d      = {i_page_in, r_opr, r_opa};
            w_target_load_d = 1'b1;
          end
        end else if (r_opr == 4'hC) begin
          w_control_d = CtlPop;
        end
      end
      3'd7: w_second_word_d = r_second_word ? 1'b0 : (r_cls != ClsNone);
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cycle       <= '0;
      r_opr         <= '0;
      r_opa         <= '0;
      r_hi          <= '0;
      r_cls         <= ClsNone;
      r_jump        <= 1'b0;
      r_second_word <= 1'b0;
      r_control     <= CtlHold;
      r_target      <= '0;
      r_target_load <= 1'b0;
    end else begin
      r_cycle       <= w_cycle_d;
      r_opr         <= w_opr_d;
      r_opa         <= w_opa_d;
      r_hi          <= w_hi_d;
      r_cls         <= w_cls_d;
      r_jump        <= w_jump_d;
      r_second_word <= w_second_word_d;
      r_control     <= w_control_d;
      r_target      <= w_target_d;
      r_target_load <= w_target_load_d;
    end
  end

  assign o_cycle       = r_cycle;
  assign o_sync        = (r_cycle == 3'd7);
  assign o_opr         = r_opr;
  assign o_opa         = r_opa;
  assign o_second_word = r_second_word;
  assign o_control     = r_control;
  assign o_target      = r_target;
  assign o_target_load = r_target_load;

`ifdef STACK_CHECK_EN
  localparam int unsigned DepthW = $clog2(STACK_SLOTS);
  localparam logic [DepthW-1:0] DepthMax = DepthW'(STACK_SLOTS - 1);

  logic [DepthW-1:0] r_depth, w_depth_d;
  logic              r_stack_err, w_stack_err_d;

  // Tracks the command as it is registered, so depth changes in the same phase it is issued.
  // Errant commands are still issued and the counter wraps.
  always_comb begin
    w_depth_d     = r_depth;
    w_stack_err_d = r_stack_err;
    if (w_control_d == CtlPush) begin
      if (r_depth == DepthMax) begin
        w_stack_err_d = 1'b1;
        w_depth_d     = '0;
      end else begin
        w_depth_d = r_depth + 1'b1;
      end
    end else if (w_control_d == CtlPop) begin
      if (r_depth == '0) begin
        w_stack_err_d = 1'b1;
        w_depth_d     = DepthMax;
      end else begin
        w_depth_d = r_depth - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_depth     <= '0;
      r_stack_err <= 1'b0;
    end else begin
      r_depth     <= w_depth_d;
      r_stack_err <= w_stack_err_d;
    end
  end

  assign o_depth     = r_depth;
  assign o_stack_err = r_stack_err;
`else
  assign o_depth     = '0;
  assign o_stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  data_in = 4'h0;
  logic [3:0]  page_in = 4'h0;
  logic        test_n = 1'b1;
  logic        carry_in = 1'b0;
  logic        acc_zero = 1'b0;
  logic        isz_nonzero = 1'b0;
  logic [2:0]  cycle;
  logic        sync;
  logic [3:0]  opr, opa;
  logic        second_word;
  logic [1:0]  control;
  logic [11:0] target;
  logic        target_load;
  logic [1:0]  depth;
  logic        stack_err;

  int errors = 0;
  int checks = 0;

  fetch_sequencer #(.STACK_SLOTS(4)) dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_data_in     (data_in),
    .i_page_in     (page_in),
    .i_test_n      (test_n),
    .i_carry_in    (carry_in),
    .i_acc_zero    (acc_zero),
    .i_isz_nonzero (isz_nonzero),
    .o_cycle       (cycle),
    .o_sync        (sync),
    .o_opr         (opr),
    .o_opa         (opa),
    .o_second_word (second_word),
    .o_control     (control),
    .o_target      (target),
    .o_target_load (target_load),
    .o_depth       (depth),
    .o_stack_err   (stack_err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycle(input logic [2:0] c);
    int n = 0;
    while (cycle !== c && n < 16) begin
      step();
      n++;
    end
    checks++;
    if (cycle !== c) begin
      errors++;
      $display("FAIL wait_cycle: got %0d need %0d", cycle, c);
    end
  endtask

  // Presents one fetched word; returns during cycle 5 of that word.
  task automatic drive_word(input logic [3:0] a, input logic [3:0] b);
    wait_cycle(3'd3);
    data_in = a;
    step();
    data_in = b;
    step();
    data_in = 4'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    step();
    reset = 1'b0;
    wait_cycle(3'd5);
    reset = 1'b1;
    step();
    step();
    step();
    checks++;
    if ({cycle, sync, opr, opa, second_word, control, target, target_load, depth, stack_err}
        !== 33'd0) begin
      errors++;
      $display("FAIL reset_outputs: cyc=%0d sync=%b opr=%h opa=%h sw=%b ctl=%0d tgt=%h ld=%b dep=%0d err=%b need all 0",
               cycle, sync, opr, opa, second_word, control, target, target_load, depth, stack_err);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cycle !== 3'(i) || sync !== (i == 7)) begin
        errors++;
        $display("FAIL cycle_count: got cyc=%0d sync=%b need cyc=%0d sync=%b",
                 cycle, sync, i, (i == 7));
      end
      step();
    end
  endtask

  task automatic test_jun();
    drive_word(4'h4, 4'hA);
    checks++;
    if (opr !== 4'h4 || opa !== 4'hA || second_word !== 1'b0) begin
      errors++;
      $display("FAIL jun_word1_latch: got opr=%h opa=%h sw=%b need 4 A 0", opr, opa, second_word);
    end
    step();
    step();
    checks++;
    if (control !== 2'd0 || target_load !== 1'b0) begin
      errors++;
      $display("FAIL jun_word1_quiet: got ctl=%0d ld=%b need 0 0", control, target_load);
    end
    step();
    checks++;
    if (second_word !== 1'b1) begin
      errors++;
      $display("FAIL jun_second_word: got %b need 1", second_word);
    end
    drive_word(4'h3, 4'hC);
    step();
    checks++;
    if (control !== 2'd0 || target_load !== 1'b0) begin
      errors++;
      $display("FAIL jun_cycle6: got ctl=%0d ld=%b need 0 0", control, target_load);
    end
    step();
    checks++;
    if (target !== 12'hA3C || target_load !== 1'b1 || control !== 2'd0) begin
      errors++;
      $display("FAIL jun_load: got tgt=%h ld=%b ctl=%0d need A3C 1 0", target, target_load, control);
    end
    step();
    checks++;
    if (target_load !== 1'b0 || second_word !== 1'b0 || target !== 12'hA3C) begin
      errors++;
      $display("FAIL jun_after: got ld=%b sw=%b tgt=%h need 0 0 A3C", target_load, second_word, target);
    end
  endtask

  task automatic test_jms();
    drive_word(4'h5, 4'h1);
    drive_word(4'h2, 4'h3);
    checks++;
    if (second_word !== 1'b1 || control !== 2'd0) begin
      errors++;
      $display("FAIL jms_cycle5: got sw=%b ctl=%0d need 1 0", second_word, control);
    end
    step();
    checks++;
    if (control !== 2'd1 || target_load !== 1'b0) begin
      errors++;
      $display("FAIL jms_push: got ctl=%0d ld=%b need 1 0", control, target_load);
    end
    step();
    checks++;
    if (control !== 2'd0 || target !== 12'h123 || target_load !== 1'b1) begin
      errors++;
      $display("FAIL jms_load: got ctl=%0d tgt=%h ld=%b need 0 123 1", control, target, target_load);
    end
    step();
  endtask

  task automatic test_jcn();
    page_in  = 4'h7;
    acc_zero = 1'b1;
    drive_word(4'h1, 4'h4);
    drive_word(4'h5, 4'h6);
    wait_cycle(3'd7);
    checks++;
    if (target !== 12'h756 || target_load !== 1'b1 || control !== 2'd0) begin
      errors++;
      $display("FAIL jcn_taken: got tgt=%h ld=%b ctl=%0d need 756 1 0", target, target_load, control);
    end
    acc_zero = 1'b0;
    drive_word(4'h1, 4'h4);
    drive_word(4'h8, 4'h9);
    wait_cycle(3'd7);
    checks++;
    if (target_load !== 1'b0 || target !== 12'h756) begin
      errors++;
      $display("FAIL jcn_not_taken: got ld=%b tgt=%h need 0 756", target_load, target);
    end
    // Inverted condition: acc_zero=0 with c=C jumps.
    drive_word(4'h1, 4'hC);
    drive_word(4'h8, 4'h9);
    wait_cycle(3'd7);
    checks++;
    if (target_load !== 1'b1 || target !== 12'h789) begin
      errors++;
      $display("FAIL jcn_invert: got ld=%b tgt=%h need 1 789", target_load, target);
    end
    // TEST pin low with c=1.
    test_n = 1'b0;
    drive_word(4'h1, 4'h1);
    drive_word(4'h2, 4'h4);
    wait_cycle(3'd7);
    test_n = 1'b1;
    checks++;
    if (target_load !== 1'b1 || target !== 12'h724) begin
      errors++;
      $display("FAIL jcn_test_pin: got ld=%b tgt=%h need 1 724", target_load, target);
    end
  endtask

  task automatic test_isz();
    page_in     = 4'h3;
    isz_nonzero = 1'b1;
    drive_word(4'h7, 4'h5);
    drive_word(4'hA, 4'hB);
    wait_cycle(3'd7);
    checks++;
    if (target_load !== 1'b1 || target !== 12'h3AB) begin
      errors++;
      $display("FAIL isz_taken: got ld=%b tgt=%h need 1 3AB", target_load, target);
    end
    isz_nonzero = 1'b0;
    drive_word(4'h7, 4'h5);
    drive_word(4'h1, 4'h2);
    wait_cycle(3'd7);
    checks++;
    if (target_load !== 1'b0 || target !== 12'h3AB) begin
      errors++;
      $display("FAIL isz_not_taken: got ld=%b tgt=%h need 0 3AB", target_load, target);
    end
  endtask

  task automatic test_bbl_fim();
    drive_word(4'hC, 4'h0);
    step();
    checks++;
    if (control !== 2'd0) begin
      errors++;
      $display("FAIL bbl_cycle6: got ctl=%0d need 0", control);
    end
    step();
    checks++;
    if (control !== 2'd2 || target_load !== 1'b0) begin
      errors++;
      $display("FAIL bbl_pop: got ctl=%0d ld=%b need 2 0", control, target_load);
    end
    step();
    checks++;
    if (second_word !== 1'b0 || control !== 2'd0) begin
      errors++;
      $display("FAIL bbl_after: got sw=%b ctl=%0d need 0 0", second_word, control);
    end
    // FIM is two words with no stack activity; word-2 data 4,5 must not act as JUN.
    drive_word(4'h2, 4'h0);
    wait_cycle(3'd0);
    checks++;
    if (second_word !== 1'b1) begin
      errors++;
      $display("FAIL fim_second_word: got %b need 1", second_word);
    end
    drive_word(4'h4, 4'h5);
    step();
    step();
    checks++;
    if (control !== 2'd0 || target_load !== 1'b0) begin
      errors++;
      $display("FAIL fim_quiet: got ctl=%0d ld=%b need 0 0", control, target_load);
    end
    step();
    checks++;
    if (second_word !== 1'b0) begin
      errors++;
      $display("FAIL fim_after: got sw=%b need 0", second_word);
    end
  endtask

  task automatic test_stack();
    logic [1:0] exp_depth [4];
    logic       exp_err [4];
    do_reset();
`ifdef STACK_CHECK_EN
    exp_depth = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_err   = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_depth = '{2'd0, 2'd0, 2'd0, 2'd0};
    exp_err   = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      drive_word(4'h5, 4'h0);
      drive_word(4'h1, 4'h0);
      wait_cycle(3'd7);
      checks++;
      if (depth !== exp_depth[i] || stack_err !== exp_err[i] || target_load !== 1'b1) begin
        errors++;
        $display("FAIL stack_push%0d: got dep=%0d err=%b ld=%b need %0d %b 1",
                 i, depth, stack_err, target_load, exp_depth[i], exp_err[i]);
      end
    end
    do_reset();
    drive_word(4'hC, 4'h0);
    wait_cycle(3'd7);
    checks++;
`ifdef STACK_CHECK_EN
    if (control !== 2'd2 || depth !== 2'd3 || stack_err !== 1'b1) begin
      errors++;
      $display("FAIL stack_underflow: got ctl=%0d dep=%0d err=%b need 2 3 1", control, depth, stack_err);
    end
`else
    if (control !== 2'd2 || depth !== 2'd0 || stack_err !== 1'b0) begin
      errors++;
      $display("FAIL stack_disabled: got ctl=%0d dep=%0d err=%b need 2 0 0", control, depth, stack_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_jun();
    test_jms();
    test_jcn();
    test_isz();
    test_bbl_fim();
    test_stack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
